// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;

    // ebreak
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0010_0073;

endpackage

// File: rtl/inst_fetch_out_stage.sv
// Output register holding the fetched instruction and its PC toward decode.
// Latency: one cycle from load to out_valid.
// Backpressure: contents frozen while out_valid && !out_ready; flush has priority over load.
module inst_fetch_out_stage #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= load_instr;
            out_pc    <= load_pc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC + boot/run/halt FSM driving a combinational InstMem; INST_FETCH_PERF_CNT_EN adds counters.
// Latency: PC to out_valid one cycle, one instruction per cycle while out_ready is high.
// Backpressure: no fetch while the output stage holds an unaccepted instruction; PC holds.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        INSTR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(DEFAULT_HALT_INSTR)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
`ifdef INST_FETCH_PERF_CNT_EN
    output logic [31:0]        fetch_count,
    output logic [15:0]        flush_count,
`endif
    output logic               halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic              load;

    // Redirects arriving during boot are dropped entirely, including the flush.
    assign redirect  = redirect_valid && (state != S_BOOT);
    assign load      = (state == S_RUN) && (!out_valid || out_ready) && !redirect_valid;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_BOOT;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN: begin
                    if (redirect) begin
                        pc <= redirect_pc & ~ADDR_W'(3);
                    end else if (load) begin
                        pc <= pc + ADDR_W'(PC_STEP);
                        if (imem_instr == HALT_INSTR) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (redirect) begin
                        pc     <= redirect_pc & ~ADDR_W'(3);
                        state  <= S_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    inst_fetch_out_stage #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_out_stage (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .flush      (redirect),
        .load_instr (imem_instr),
        .load_pc    (pc),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
    );

`ifdef INST_FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (load && (fetch_count != '1))
                fetch_count <= fetch_count + 32'd1;
            if (redirect && out_valid && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [31:0] HALT = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;
`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[int'(imem_addr) / 4];

    inst_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef INST_FETCH_PERF_CNT_EN
        .fetch_count    (fetch_count),
        .flush_count    (flush_count),
`endif
        .halted         (halted)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [7:0]  rpc;
        logic        ev;
        logic [7:0]  epc;
        logic [31:0] ei;
        logic [7:0]  ea;
        logic        eh;
    } vec_t;

    vec_t tbl [24];

    // Spec-level reference model state
    int  m_pc, m_opc, m_fetch, m_flush;
    bit  m_v, m_halt, m_boot;
    logic [31:0] m_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, rdy, rv, input logic [7:0] rpc,
                                input logic ev, input logic [7:0] epc,
                                input logic [31:0] ei, input logic [7:0] ea, input logic eh);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ei = ei; v.ea = ea; v.eh = eh;
        return v;
    endfunction

    task automatic model_step(input bit r, input bit rdy, input bit rv, input int rpc);
        if (r) begin
            m_pc = 0; m_v = 0; m_instr = 0; m_opc = 0;
            m_halt = 0; m_boot = 1; m_fetch = 0; m_flush = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (rv) begin
            if (m_v) m_flush++;
            m_pc = rpc - (rpc % 4);
            m_v = 0;
            m_halt = 0;
        end else if (!m_halt && (!m_v || rdy)) begin
            m_instr = mem[m_pc / 4];
            m_opc = m_pc;
            m_v = 1;
            m_fetch++;
            m_pc = (m_pc + 4) % 256;
            if (m_instr == HALT) m_halt = 1;
        end else if (m_v && rdy) begin
            m_v = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (i << 20);
        mem[0] = 32'h0000_7033;
        mem[3] = 32'h0030_8193;
        mem[4] = HALT;

        tbl[0]  = mk(1,1,0,8'h00, 0,8'h00,32'h0,          8'h00,0);
        tbl[1]  = mk(1,1,0,8'h00, 0,8'h00,32'h0,          8'h00,0);
        tbl[2]  = mk(0,1,0,8'h00, 0,8'h00,32'h0,          8'h00,0);
        tbl[3]  = mk(0,1,0,8'h00, 1,8'h00,32'h0000_7033,  8'h04,0);
        tbl[4]  = mk(0,1,0,8'h00, 1,8'h04,32'h0010_0013,  8'h08,0);
        tbl[5]  = mk(0,0,0,8'h00, 1,8'h04,32'h0010_0013,  8'h08,0);
        tbl[6]  = mk(0,0,0,8'h00, 1,8'h04,32'h0010_0013,  8'h08,0);
        tbl[7]  = mk(0,0,0,8'h00, 1,8'h04,32'h0010_0013,  8'h08,0);
        tbl[8]  = mk(0,1,0,8'h00, 1,8'h08,32'h0020_0013,  8'h0C,0);
        tbl[9]  = mk(0,1,1,8'h0E, 0,8'h00,32'h0,          8'h0C,0);
        tbl[10] = mk(0,1,0,8'h00, 1,8'h0C,32'h0030_8193,  8'h10,0);
        tbl[11] = mk(0,1,0,8'h00, 1,8'h10,HALT,           8'h14,1);
        tbl[12] = mk(0,1,0,8'h00, 0,8'h00,32'h0,          8'h14,1);
        tbl[13] = mk(0,1,0,8'h00, 0,8'h00,32'h0,          8'h14,1);
        tbl[14] = mk(0,1,1,8'h00, 0,8'h00,32'h0,          8'h00,0);
        tbl[15] = mk(0,1,0,8'h00, 1,8'h00,32'h0000_7033,  8'h04,0);
        tbl[16] = mk(0,0,0,8'h00, 1,8'h00,32'h0000_7033,  8'h04,0);
        tbl[17] = mk(1,0,0,8'h00, 0,8'h00,32'h0,          8'h00,0);
        tbl[18] = mk(0,1,0,8'h00, 0,8'h00,32'h0,          8'h00,0);
        tbl[19] = mk(0,1,0,8'h00, 1,8'h00,32'h0000_7033,  8'h04,0);
        tbl[20] = mk(0,1,1,8'hFC, 0,8'h00,32'h0,          8'hFC,0);
        tbl[21] = mk(0,1,0,8'h00, 1,8'hFC,32'h03F0_0013,  8'h00,0);
        tbl[22] = mk(0,1,0,8'h00, 1,8'h00,32'h0000_7033,  8'h04,0);
        tbl[23] = mk(0,1,0,8'h00, 1,8'h04,32'h0010_0013,  8'h08,0);

        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;

        // Directed sequence: boot, stall, redirect, halt, reset mid-stall, wrap
        for (int i = 0; i < 24; i++) begin
            reset          = tbl[i].rst;
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d imem_addr", i), 32'(imem_addr), 32'(tbl[i].ea));
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'(tbl[i].eh));
            if (tbl[i].ev || tbl[i].rst) begin
                chk($sformatf("vec%0d out_pc", i), 32'(out_pc), 32'(tbl[i].epc));
                chk($sformatf("vec%0d out_instr", i), out_instr, tbl[i].ei);
            end
        end
`ifdef INST_FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'd4);
        chk("flush_count", 32'(flush_count), 32'd1);
`endif

        // Randomized phase against the reference model
        model_step(1, 0, 0, 0);
        reset = 1'b1; redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(199, 0) == 0);
            out_ready      = ($urandom_range(99, 0) < 70);
            redirect_valid = ($urandom_range(99, 0) < 7);
            redirect_pc    = 8'($urandom_range(255, 0));
            if ($urandom_range(3, 0) == 0) redirect_pc = 8'($urandom_range(5, 0) * 4 + 8);
            model_step(reset, out_ready, redirect_valid, int'(redirect_pc));
            @(posedge clk);
            #1;
            chk("rand out_valid", 32'(out_valid), 32'(m_v));
            chk("rand imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("rand halted", 32'(halted), 32'(m_halt));
            if (m_v) begin
                chk("rand out_pc", 32'(out_pc), 32'(m_opc));
                chk("rand out_instr", out_instr, m_instr);
            end
`ifdef INST_FETCH_PERF_CNT_EN
            chk("rand fetch_count", fetch_count, 32'(m_fetch));
            chk("rand flush_count", 32'(flush_count), 32'(m_flush));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
